// File: rtl/pose_ascii_framer.sv
// Pose-sample to ASCII text framer: each signed 16-bit channel becomes "+ddddd"/"-ddddd",
// channels are joined by SEP_CHAR and the line ends with CR LF, one byte per FIFO write.
module pose_ascii_framer #(
  parameter int          CH_NUM   = 3,
  parameter logic [7:0]  SEP_CHAR = 8'h2C
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [16*CH_NUM-1:0]  pose_data_in,
  input  logic                  pose_data_vld,
  output logic                  pose_rdy,
  output logic [7:0]            tx_data_out,
  output logic                  tx_data_vld,
  input  logic                  tx_rdy,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, SIGN, DIG, SEP, CR, LF} state_t;

  state_t             state;
  logic signed [15:0] chan_q [4];
  logic [1:0]         ch;
  logic [2:0]         k;
  logic [15:0]        mag;
  logic [3:0]         digit;
  logic               pend;
  logic               rdy_q;
  logic [7:0]         data_q;

  logic [63:0]        pose_ext;
  logic signed [15:0] first_chan;
  logic signed [15:0] next_chan;
  logic [15:0]        w;
  logic [15:0]        mag_sub;
  logic               fire;

  // Magnitude is kept unsigned so that -32768 maps to 32768 without wrapping.
  function automatic logic [15:0] magnitude(input logic signed [15:0] v);
    logic signed [15:0] neg;
    neg = -v;
    return v[15] ? unsigned'(neg) : unsigned'(v);
  endfunction

  function automatic logic [7:0] sign_char(input logic signed [15:0] v);
    return v[15] ? 8'h2D : 8'h2B;
  endfunction

  function automatic logic [15:0] weight(input logic [2:0] idx);
    case (idx)
      3'd0:    return 16'd10000;
      3'd1:    return 16'd1000;
      3'd2:    return 16'd100;
      3'd3:    return 16'd10;
      default: return 16'd1;
    endcase
  endfunction

  assign pose_ext    = 64'(pose_data_in);
  assign first_chan  = signed'(pose_data_in[15:0]);
  assign next_chan   = chan_q[ch + 2'd1];
  assign w           = weight(k);
  assign mag_sub     = mag - w;
  assign fire        = pend & tx_rdy;

  assign tx_data_out = data_q;
  assign tx_data_vld = fire;
  assign pose_rdy    = rdy_q;
  assign busy        = (state != IDLE);

  // pend is set one cycle ahead of each byte so an emit costs no extra cycle after its count.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state  <= IDLE;
      ch     <= 2'd0;
      k      <= 3'd0;
      mag    <= 16'd0;
      digit  <= 4'd0;
      pend   <= 1'b0;
      rdy_q  <= 1'b0;
      data_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (pose_data_vld && rdy_q) begin
            for (int i = 0; i < 4; i++) chan_q[i] <= signed'(pose_ext[16*i +: 16]);
            ch     <= 2'd0;
            mag    <= magnitude(first_chan);
            data_q <= sign_char(first_chan);
            pend   <= 1'b1;
            rdy_q  <= 1'b0;
            state  <= SIGN;
          end
        end
        SIGN: begin
          if (fire) begin
            state  <= DIG;
            k      <= 3'd0;
            digit  <= 4'd0;
            data_q <= 8'h30;
            pend   <= (mag < weight(3'd0));
          end
        end
        DIG: begin
          if (!pend) begin
            mag    <= mag_sub;
            digit  <= digit + 4'd1;
            data_q <= 8'h31 + {4'h0, digit};
            pend   <= (mag_sub < w);
          end else if (tx_rdy) begin
            if (k != 3'd4) begin
              k      <= k + 3'd1;
              digit  <= 4'd0;
              data_q <= 8'h30;
              pend   <= (mag < weight(k + 3'd1));
            end else if (ch != 2'(CH_NUM - 1)) begin
              state  <= SEP;
              data_q <= SEP_CHAR;
            end else begin
              state  <= CR;
              data_q <= 8'h0D;
            end
          end
        end
        SEP: begin
          if (fire) begin
            ch     <= ch + 2'd1;
            mag    <= magnitude(next_chan);
            data_q <= sign_char(next_chan);
            state  <= SIGN;
          end
        end
        CR: begin
          if (fire) begin
            data_q <= 8'h0A;
            state  <= LF;
          end
        end
        LF: begin
          if (fire) begin
            pend  <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pose_ascii_framer.sv
// Bench for pose_ascii_framer: frames are compared against a text model built with
// integer division, under steady and randomly stalled FIFO readiness.
module tb_pose_ascii_framer;
  localparam int CH = 3;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic [47:0]   pose_data_in;
  logic          pose_data_vld;
  logic          pose_rdy;
  logic [7:0]    tx_data_out;
  logic          tx_data_vld;
  logic          tx_rdy;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_cyc[$];
  int rdy_cycle, viol, dur_exp;

  always #5 clk_in = ~clk_in;

  pose_ascii_framer #(.CH_NUM(CH), .SEP_CHAR(8'h2C)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .pose_data_in(pose_data_in),
    .pose_data_vld(pose_data_vld), .pose_rdy(pose_rdy), .tx_data_out(tx_data_out),
    .tx_data_vld(tx_data_vld), .tx_rdy(tx_rdy), .busy(busy)
  );

  // Reference text and cycle count derived from the value itself.
  task automatic build_exp(input logic [47:0] s);
    int v, m, wgt, dig;
    exp_q.delete();
    dur_exp = 7*CH + 1;
    for (int c = 0; c < CH; c++) begin
      v = int'($signed(s[16*c +: 16]));
      m = (v < 0) ? -v : v;
      exp_q.push_back((v < 0) ? 8'h2D : 8'h2B);
      wgt = 10000;
      for (int d = 0; d < 5; d++) begin
        dig = (m / wgt) % 10;
        exp_q.push_back(8'(8'h30 + dig));
        dur_exp += dig;
        wgt /= 10;
      end
      if (c < CH-1) exp_q.push_back(8'h2C);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Sends one sample and records every byte strike until pose_rdy returns.
  task automatic run_frame(input logic [47:0] s, input int rnd, input int pulse_at);
    got_q.delete(); got_cyc.delete();
    viol = 0; rdy_cycle = -1;
    @(negedge clk_in);
    pose_data_in = s; pose_data_vld = 1'b1; tx_rdy = 1'b1;
    @(negedge clk_in);
    pose_data_vld = 1'b0;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      tx_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pose_data_vld = (cyc == pulse_at || cyc == pulse_at + 1);
      #1;
      if (pose_rdy) begin rdy_cycle = cyc; break; end
      if (tx_data_vld && !tx_rdy) viol++;
      if (tx_data_vld) begin got_q.push_back(tx_data_out); got_cyc.push_back(cyc); end
      @(negedge clk_in);
    end
    pose_data_vld = 1'b0; tx_rdy = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pose_data_vld = 1'b1; tx_rdy = 1'b1;
    pose_data_in = {16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in); #1;
      total++;
      if (tx_data_vld !== 1'b0 || busy !== 1'b0 || pose_rdy !== 1'b0 || tx_data_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_state cyc%0d got vld=%b busy=%b rdy=%b data=%h exp 0 0 0 00",
                 i, tx_data_vld, busy, pose_rdy, tx_data_out);
      end
    end
    @(negedge clk_in);
    rst_n = 1'b1; pose_data_vld = 1'b0;
    @(negedge clk_in); #1;
    total++;
    if (pose_rdy !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b busy=%b exp rdy=1 busy=0", pose_rdy, busy);
    end
  endtask

  task automatic test_known;
    logic [47:0] s;
    s = {16'sd32767, -16'sd12, 16'sd1234};
    build_exp(s);
    run_frame(s, 0, 0);
    total++;
    if (got_q.size() != 22) begin bad++; $display("FAIL known_len got=%0d exp=22", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL known_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (rdy_cycle != dur_exp + 1) begin
      bad++; $display("FAIL known_duration got=%0d exp=%0d", rdy_cycle, dur_exp + 1);
    end
  endtask

  task automatic test_zero;
    build_exp(48'h0);
    run_frame(48'h0, 0, 0);
    total++;
    if (got_q.size() != 22) begin bad++; $display("FAIL zero_len got=%0d exp=22", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i] || got_cyc[i] != i + 1) begin
        bad++; $display("FAIL zero_byte[%0d] got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], i + 1);
      end
    end
    total++;
    if (rdy_cycle != 23) begin bad++; $display("FAIL zero_rdy_cycle got=%0d exp=23", rdy_cycle); end
  endtask

  task automatic test_extremes;
    logic [47:0] s;
    s = {16'h0000, 16'hFFFF, 16'h8000};
    build_exp(s);
    run_frame(s, 0, 0);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL extreme_len got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL extreme_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (rdy_cycle != dur_exp + 1) begin
      bad++; $display("FAIL extreme_duration got=%0d exp=%0d", rdy_cycle, dur_exp + 1);
    end
  endtask

  task automatic test_stall;
    logic [47:0] s;
    s = {16'sd32767, -16'sd12, 16'sd1234};
    build_exp(s);
    run_frame(s, 1, 0);
    total++;
    if (got_q.size() != 22 || rdy_cycle < 0) begin
      bad++; $display("FAIL stall_len got=%0d rdy_at=%0d exp=22", got_q.size(), rdy_cycle);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL stall_vld_without_rdy got=%0d exp=0", viol); end
  endtask

  task automatic test_random;
    logic [47:0] s;
    int rnd;
    for (int n = 0; n < 6; n++) begin
      s = {16'($urandom), 16'($urandom), 16'($urandom)};
      rnd = n % 2;
      build_exp(s);
      run_frame(s, rnd, 0);
      total++;
      if (got_q.size() != exp_q.size() || viol != 0) begin
        bad++; $display("FAIL rand%0d_len got=%0d viol=%0d exp=%0d viol=0", n, got_q.size(), viol, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_byte[%0d] s=%h got=%h exp=%h", n, i, s, got_q[i], exp_q[i]);
        end
      end
      if (rnd == 0) begin
        total++;
        if (rdy_cycle != dur_exp + 1) begin
          bad++; $display("FAIL rand%0d_duration got=%0d exp=%0d", n, rdy_cycle, dur_exp + 1);
        end
      end
    end
  endtask

  task automatic test_abort;
    int seen;
    logic [47:0] s;
    seen = 0;
    @(negedge clk_in);
    pose_data_in = {16'sd32767, -16'sd12, 16'sd1234}; pose_data_vld = 1'b1; tx_rdy = 1'b1;
    @(negedge clk_in);
    pose_data_vld = 1'b0;
    for (int cyc = 0; cyc < 60 && seen < 5; cyc++) begin
      #1;
      if (tx_data_vld) seen++;
      @(negedge clk_in);
    end
    rst_n = 1'b0; tx_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (tx_data_vld !== 1'b0) begin bad++; $display("FAIL abort_strike cyc%0d got=%b exp=0", i, tx_data_vld); end
      @(negedge clk_in);
    end
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    @(negedge clk_in);
    rst_n = 1'b1; tx_rdy = 1'b1;
    @(negedge clk_in); #1;
    total++;
    if (pose_rdy !== 1'b1) begin bad++; $display("FAIL abort_rdy got=%b exp=1", pose_rdy); end
    s = {16'd0, 16'd0, 16'd5};
    build_exp(s);
    run_frame(s, 0, 3);
    total++;
    if (got_q.size() != 22) begin bad++; $display("FAIL abort_len got=%0d exp=22", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL abort_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in); #1;
      if (tx_data_vld || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL busy_pulse_extra_frame got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset;
    test_known;
    test_zero;
    test_extremes;
    test_stall;
    test_random;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
